neander_ctrl: RTL and testbench

NEANDER_CTRL -- requirements
Module: neander_ctrl

---
 rtl/neander_ctrl.sv | 112 +++++++++++
 tb/tb_neander_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neander_ctrl.sv
// Neander-style accumulator control unit: four-word program memory, fetch/execute
// sequencing, accumulator datapath and Moore-decoded memory strobes.
module neander_ctrl #(
  parameter logic [1:0] RESET_PC = 2'b00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] mem_end,
  output logic       mem_write,
  output logic       mem_read,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout,
  output logic [7:0] ac,
  output logic [1:0] pc,
  output logic       flag_n,
  output logic       flag_z,
  output logic       running,
  output logic       halted,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] ir;
  logic [3:0] op;

  assign op = ir[7:4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes depend only on state and IR, so an async reset drops them at once.
  always_comb begin
    state_next = state;
    mem_end    = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        mem_end    = pc;
        mem_read   = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        case (op)
          4'h1: begin
            mem_end   = ir[1:0];
            mem_write = 1'b1;
          end
          4'h2, 4'h3, 4'h4, 4'h5: begin
            mem_end  = ir[1:0];
            mem_read = 1'b1;
          end
          default: ;
        endcase
        state_next = (op == 4'hF) ? HALT : FETCH;
      end
      HALT: begin
        if (start) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir <= 8'h00;
      ac <= 8'h00;
      pc <= RESET_PC;
    end else if (state == FETCH) begin
      ir <= mem_dout;
      pc <= pc + 2'd1;
    end else if (state == EXEC) begin
      // Branch conditions use the flags of the accumulator entering EXEC.
      case (op)
        4'h2: ac <= mem_dout;
        4'h3: ac <= ac + mem_dout;
        4'h4: ac <= ac | mem_dout;
        4'h5: ac <= ac & mem_dout;
        4'h6: ac <= ~ac;
        4'h8: pc <= ir[1:0];
        4'h9: if (flag_n) pc <= ir[1:0];
        4'hA: if (flag_z) pc <= ir[1:0];
        default: ;
      endcase
    end
  end

  assign mem_din   = ac;
  assign flag_n    = ac[7];
  assign flag_z    = (ac == 8'h00);
  assign running   = (state == FETCH) || (state == EXEC);
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_neander_ctrl.sv
// Bench for neander_ctrl: instruction-level reference machine, per-cycle output
// checks, a write scoreboard and directed programs plus random programs.
module tb_neander_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mem_end;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [7:0] ac;
  logic [1:0] pc;
  logic       flag_n;
  logic       flag_z;
  logic       running;
  logic       halted;
  logic [1:0] state_dbg;

  neander_ctrl #(.RESET_PC(2'b00)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_end(mem_end), .mem_write(mem_write), .mem_read(mem_read),
    .mem_din(mem_din), .mem_dout(mem_dout), .ac(ac), .pc(pc),
    .flag_n(flag_n), .flag_z(flag_z), .running(running), .halted(halted),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // memory seen by the DUT
  logic [7:0] mem [4];
  logic [9:0] wr_log [$];
  assign mem_dout = mem_read ? mem[mem_end] : 8'h00;

  always @(posedge clock) begin
    if (reset_n && mem_write) begin
      mem[mem_end] <= mem_din;
      wr_log.push_back({mem_end, mem_din});
    end
  end

  // reference machine: one instruction = fetch cycle + execute cycle
  logic [7:0] ref_mem [4];
  logic [9:0] exp_q [$];
  bit         m_run, m_exec, m_halt;
  logic [7:0] m_ac, m_ir;
  logic [1:0] m_pc;

  int vectors = 0;
  int miscompares = 0;
  int test_writes = 0;
  logic [9:0] last_wr = 10'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_exec = 0; m_halt = 0;
    m_ac = 8'h00; m_ir = 8'h00; m_pc = 2'b00;
  endtask

  task automatic model_advance(input logic st);
    logic [7:0] opnd;
    int op;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_halt = 0; m_exec = 0;
      end
    end else if (!m_exec) begin
      m_ir   = ref_mem[m_pc];
      m_pc   = m_pc + 2'd1;
      m_exec = 1;
    end else begin
      op     = int'(m_ir[7:4]);
      opnd   = ref_mem[m_ir[1:0]];
      m_exec = 0;
      case (op)
        1: begin
          ref_mem[m_ir[1:0]] = m_ac;
          exp_q.push_back({m_ir[1:0], m_ac});
        end
        2: m_ac = opnd;
        3: m_ac = 8'((int'(m_ac) + int'(opnd)) % 256);
        4: m_ac = m_ac | opnd;
        5: m_ac = m_ac & opnd;
        6: m_ac = 8'hFF - m_ac;
        8: m_pc = m_ir[1:0];
        9: if (m_ac >= 8'h80) m_pc = m_ir[1:0];
        10: if (m_ac == 8'h00) m_pc = m_ir[1:0];
        15: begin m_run = 0; m_halt = 1; end
        default: ;
      endcase
    end
  endtask

  // compare process: every output against the reference, then the write scoreboard
  task automatic compare_all();
    logic [1:0] e_end;
    logic       e_rd, e_wr;
    logic [9:0] a, e;
    int op;
    e_end = 2'b00; e_rd = 0; e_wr = 0;
    op = int'(m_ir[7:4]);
    if (m_run && !m_exec) begin
      e_end = m_pc; e_rd = 1;
    end else if (m_run && m_exec) begin
      if (op == 1) begin e_end = m_ir[1:0]; e_wr = 1; end
      else if (op >= 2 && op <= 5) begin e_end = m_ir[1:0]; e_rd = 1; end
    end
    check("ac", 32'(ac), 32'(m_ac));
    check("pc", 32'(pc), 32'(m_pc));
    check("flag_n", 32'(flag_n), 32'(m_ac >= 8'h80));
    check("flag_z", 32'(flag_z), 32'(m_ac == 8'h00));
    check("running", 32'(running), 32'(m_run));
    check("halted", 32'(halted), 32'(m_halt));
    check("mem_end", 32'(mem_end), 32'(e_end));
    check("mem_read", 32'(mem_read), 32'(e_rd));
    check("mem_write", 32'(mem_write), 32'(e_wr));
    check("mem_din", 32'(mem_din), 32'(m_ac));
    check("wr_count", 32'(wr_log.size()), 32'(exp_q.size()));
    while (wr_log.size() > 0 && exp_q.size() > 0) begin
      a = wr_log.pop_front();
      e = exp_q.pop_front();
      check("wr_data", 32'(a), 32'(e));
      last_wr = a;
      test_writes++;
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic cycle(input logic st);
    start = st;
    @(posedge clock);
    #1;
    model_advance(st);
    compare_all();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_mem_write", 32'(mem_write), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    start = 1'b0;
    compare_all();
  endtask

  task automatic load_prog(input logic [7:0] w0, w1, w2, w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    ref_mem[0] = w0; ref_mem[1] = w1; ref_mem[2] = w2; ref_mem[3] = w3;
    test_writes = 0;
  endtask

  // start sampled at the first edge, then count edges until halted shows
  task automatic run_until_halt(input int budget, output int edges);
    edges = 0;
    cycle(1'b1);
    while (halted !== 1'b1 && edges < budget) begin
      cycle(1'b0);
      edges++;
    end
    if (halted !== 1'b1) check("halt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int edges;
    int guard;
    #2;
    apply_reset();
    check("reset_ac", 32'(ac), 32'h00);
    check("reset_flag_z", 32'(flag_z), 32'd1);
    check("reset_pc", 32'(pc), 32'd0);

    // idle holds with start low
    load_prog(8'h23, 8'h32, 8'hF0, 8'h05);
    repeat (3) cycle(1'b0);
    check("idle_running", 32'(running), 32'd0);

    // LDA 3, ADD 2, HLT
    run_until_halt(40, edges);
    check("p1_edges", 32'(edges), 32'd6);
    check("p1_ac", 32'(ac), 32'hF5);
    check("p1_flag_n", 32'(flag_n), 32'd1);
    check("p1_pc", 32'(pc), 32'd3);
    // HALT holds, then start resumes at pc=3 (NOP at word 3, wrap, rerun)
    repeat (3) cycle(1'b0);
    check("halt_hold_pc", 32'(pc), 32'd3);
    run_until_halt(40, edges);
    check("resume_edges", 32'(edges), 32'd8);
    check("resume_ac", 32'(ac), 32'hF5);

    // LDA 2, STA 3: one write of A5 to word 3 within one pass of the program
    apply_reset();
    load_prog(8'h22, 8'h13, 8'hA5, 8'h00);
    cycle(1'b1);
    repeat (8) cycle(1'b0);
    check("p2_writes", 32'(test_writes), 32'd1);
    check("p2_last_wr", 32'(last_wr), 32'({2'd3, 8'hA5}));
    check("p2_word3", 32'(mem[3]), 32'hA5);

    // NOT, JN 3 taken, HLT at word 3 -> pc wraps to 0
    apply_reset();
    load_prog(8'h60, 8'h93, 8'hF0, 8'hF0);
    run_until_halt(40, edges);
    check("p3_ac", 32'(ac), 32'hFF);
    check("p3_pc", 32'(pc), 32'd0);

    // LDA 3 (01), ADD 0 (23) -> 24
    apply_reset();
    load_prog(8'h23, 8'h30, 8'hF0, 8'h01);
    run_until_halt(40, edges);
    check("p4_ac", 32'(ac), 32'h24);
    // LDA 3 (DD), ADD 0 (23) -> 100 with carry dropped
    apply_reset();
    load_prog(8'h23, 8'h30, 8'hF0, 8'hDD);
    run_until_halt(40, edges);
    check("p5_ac", 32'(ac), 32'h00);
    check("p5_flag_z", 32'(flag_z), 32'd1);

    // start held high while running; reset lands inside STA's execute cycle
    apply_reset();
    load_prog(8'h22, 8'h13, 8'h77, 8'hF0);
    cycle(1'b1);
    guard = 0;
    while (!(m_exec && m_ir[7:4] == 4'h1) && guard < 10) begin
      cycle(1'b1);
      guard++;
    end
    check("sta_reached", 32'(guard < 10), 32'd1);
    check("sta_mem_write", 32'(mem_write), 32'd1);
    #2;
    apply_reset();
    check("p6_word3", 32'(mem[3]), 32'hF0);
    check("p6_pc", 32'(pc), 32'd0);
    check("p6_ac", 32'(ac), 32'h00);
    check("p6_idle", 32'(running | halted), 32'd0);

    // random programs with random start activity and occasional resets
    for (int p = 0; p < 8; p++) begin
      apply_reset();
      load_prog(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 60) == 0) apply_reset();
        else cycle(1'($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
